// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline hazard controller:
//   - mul_state_e   : multiplier stall FSM encoding (IDLE=0, MUL_WAIT=1)
//   - REG_AW_DEFAULT: default register-address width
//   - CNT_W         : width of the multiplier stall down-counter
//   - hazard_ctrl_t : bundle of all pipeline-register control outputs
//   - CTRL_*        : the control bundles for each hazard case, including
//                     the all-zero bundle used while reset is asserted
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } mul_state_e;

  localparam int REG_AW_DEFAULT = 5;
  localparam int CNT_W          = 4;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic mul_busy;
  } hazard_ctrl_t;

  // Everything off: driven while reset is asserted.
  localparam hazard_ctrl_t CTRL_ZERO = '0;

  // No hazard: every stage advances normally.
  localparam hazard_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_bubble: 1'b0, mul_busy: 1'b0
  };

  // Taken branch: fetch the target, squash IF/ID and ID/EX (a flushed
  // register must still be enabled to load the NOP / zero control), and
  // drop the instruction leaving EX.
  localparam hazard_ctrl_t CTRL_FLUSH = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_bubble: 1'b1, mul_busy: 1'b0
  };

  // Multiplier still computing: freeze front end and ID/EX, feed a bubble
  // into MEM so the unfinished MUL is not committed twice.
  localparam hazard_ctrl_t CTRL_MUL_STALL = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_bubble: 1'b1, mul_busy: 1'b1
  };

  // Load-use: hold PC and IF/ID for one cycle, inject a bubble into EX.
  localparam hazard_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_bubble: 1'b0, mul_busy: 1'b0
  };

endpackage

// File: rtl/pipeline_hazard_ctrl_mul_stall_timer.sv
// ---------------------------------------------------------------------------
// mul_stall_timer
// Tracks a multi-cycle MUL occupying EX and asserts a stall for exactly
// MUL_LAT-1 cycles per MUL. A taken branch (abort) cancels the sequence.
//
// Ports
//   clk        in   rising-edge clock
//   arst       in   asynchronous reset, active-high
//   ex_is_mul  in   instruction in EX is a MUL
//   abort      in   taken branch in MEM; kills the MUL in EX
//   mul_stall  out  pipeline must hold this cycle for the MUL
//   mul_busy   out  MUL stall actually taking effect (not overridden by abort)
// Parameters
//   MUL_LAT    EX cycles of a MUL, 1..16 (1 = single-cycle, never stalls)
// ---------------------------------------------------------------------------
module mul_stall_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic ex_is_mul,
  input  logic abort,
  output logic mul_stall,
  output logic mul_busy
);

  localparam bit              MULTI    = (MUL_LAT > 1);
  // The entry cycle is itself a stall cycle, so the counter covers the
  // remaining MUL_LAT-2 stalls and reaches zero on the release cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI ? MUL_LAT - 2 : 0);

  mul_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is only ever written with non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (abort) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_is_mul && MULTI) begin
            state_q <= MUL_WAIT;
            cnt_q   <= CNT_LOAD;
          end
        end
        MUL_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Release cycle: the MUL leaves EX at this edge.
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // In IDLE a MUL arriving in EX stalls immediately (same cycle); in
  // MUL_WAIT the stall lasts until the counter has drained.
  assign mul_stall = ((state_q == IDLE) && ex_is_mul && MULTI) ||
                     ((state_q == MUL_WAIT) && (cnt_q != '0));

  assign mul_busy  = mul_stall && !abort;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard / stall / flush controller for the 5-stage pipeline with a
// multi-cycle multiplier. Sits beside ID and drives the enables and
// bubble/flush controls of PC, IF/ID, ID/EX and EX/MEM.
//
// Priority (exactly one case applies per cycle):
//   1. taken branch in MEM  -> flush IF/ID, ID/EX, bubble EX/MEM, abort MUL
//   2. MUL stall            -> freeze PC, IF/ID, ID/EX, bubble EX/MEM
//   3. load-use hazard      -> freeze PC, IF/ID, bubble ID/EX
//   4. none                 -> all stages advance
// All outputs are combinational and forced to 0 while arst is high.
//
// Ports
//   clk, arst                 clock, asynchronous active-high reset
//   id_rs1, id_rs2            source registers of the instruction in ID
//   id_use_rs1, id_use_rs2    instruction in ID actually reads rs1 / rs2
//   ex_memread, ex_rd         instruction in EX is a load / its destination
//   ex_is_mul                 instruction in EX is a MUL
//   mem_br_taken              branch in MEM resolved taken
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble,
//   mul_busy                  pipeline control outputs
//   stall_cnt, flush_cnt      performance counters (optional, see below)
//
// Configuration
//   HAZARD_PERF_CNT_EN : when defined, adds 32-bit stall_cnt (cycles with
//   pc_en low) and flush_cnt (taken-branch cycles) outputs.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int REG_AW  = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_mul,
  input  logic              mem_br_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_bubble,
  output logic              mul_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic         mul_stall;
  logic         mul_busy_raw;
  logic         lu_hit;
  hazard_ctrl_t ctrl;

  mul_stall_timer #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_timer (
    .clk       (clk),
    .arst      (arst),
    .ex_is_mul (ex_is_mul),
    .abort     (mem_br_taken),
    .mul_stall (mul_stall),
    .mul_busy  (mul_busy_raw)
  );

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu_hit = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

  // NOTE: ctrl gets a full default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    ctrl = CTRL_RUN;
    if (arst) begin
      ctrl = CTRL_ZERO;
    end else if (mem_br_taken) begin
      ctrl = CTRL_FLUSH;
    end else if (mul_stall) begin
      // A load-use hazard behind the MUL is simply held in ID; it is seen
      // again once the stall releases.
      ctrl          = CTRL_MUL_STALL;
      ctrl.mul_busy = mul_busy_raw;
    end else if (lu_hit) begin
      ctrl = CTRL_LOAD_USE;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_en      = ctrl.id_ex_en;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign mul_busy      = ctrl.mul_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl.pc_en) stall_cnt_d = stall_cnt_q + 32'd1;
    if (mem_br_taken) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // NOTE: only these counters carry reset; they are plain registers, not
  // a memory, so clearing them on arst costs nothing.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Three controller instances (MUL_LAT = 2, 3, 4) each with their own input
// set and a shared reset. Every cycle the expected control vector of every
// instance is queued when the stimulus is applied; a negedge monitor pops
// and compares it against the combinational outputs.
// Expected vector bit order:
//   {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble, mul_busy}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       ex_is_mul;
    logic       mem_br_taken;
  } in_t;

  typedef struct {
    string           tag;
    logic [2:0][6:0] exp;
  } sb_t;

  localparam logic [6:0] E_ZERO  = 7'b0000000;
  localparam logic [6:0] E_RUN   = 7'b1101000;
  localparam logic [6:0] E_FLUSH = 7'b1111110;
  localparam logic [6:0] E_MUL   = 7'b0000011;
  localparam logic [6:0] E_LU    = 7'b0001100;

  logic       clk = 1'b0;
  logic       arst;
  in_t        din  [3];
  logic [6:0] dout [3];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt [3];
  logic [31:0] flush_cnt [3];
`endif

  sb_t sb[$];
  sb_t cur;
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_bubble, mul_busy;

    pipeline_hazard_ctrl #(
      .MUL_LAT (2 + g),
      .REG_AW  (5)
    ) u_dut (
      .clk           (clk),
      .arst          (arst),
      .id_rs1        (din[g].id_rs1),
      .id_rs2        (din[g].id_rs2),
      .id_use_rs1    (din[g].id_use_rs1),
      .id_use_rs2    (din[g].id_use_rs2),
      .ex_memread    (din[g].ex_memread),
      .ex_rd         (din[g].ex_rd),
      .ex_is_mul     (din[g].ex_is_mul),
      .mem_br_taken  (din[g].mem_br_taken),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .if_id_flush   (if_id_flush),
      .id_ex_en      (id_ex_en),
      .id_ex_flush   (id_ex_flush),
      .ex_mem_bubble (ex_mem_bubble),
      .mul_busy      (mul_busy)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt     (stall_cnt[g]),
      .flush_cnt     (flush_cnt[g])
`endif
    );

    assign dout[g] = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                      ex_mem_bubble, mul_busy};
  end

  // Scoreboard monitor: compare away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dout[k] !== cur.exp[k]) begin
          failures++;
          $display("FAIL %s dut(MUL_LAT=%0d) got=%b expected=%b t=%0t",
                   cur.tag, k + 2, dout[k], cur.exp[k], $time);
        end
      end
    end
  end

  // Queue the expectation for the inputs just applied, then advance to
  // just after the next rising edge.
  task automatic step(input string tag, input logic [6:0] e0,
                      input logic [6:0] e1, input logic [6:0] e2);
    sb_t e;
    e.tag    = tag;
    e.exp[0] = e0;
    e.exp[1] = e1;
    e.exp[2] = e2;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) din[k] = '0;
  endtask

  task automatic set_lu(input int k);
    din[k].ex_memread = 1'b1;
    din[k].ex_rd      = 5'd5;
    din[k].id_rs1     = 5'd5;
    din[k].id_use_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) din[k] = in_t'($urandom);
      step("reset_outputs_zero", E_ZERO, E_ZERO, E_ZERO);
    end
    idle_all();
    arst = 1'b0;
    step("reset_release_run", E_RUN, E_RUN, E_RUN);
    step("reset_idle_run", E_RUN, E_RUN, E_RUN);
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 3; k++) set_lu(k);
    step("lu_rs1_hit", E_LU, E_LU, E_LU);
    idle_all();
    step("lu_bubble_then_run", E_RUN, E_RUN, E_RUN);
    for (int k = 0; k < 3; k++) begin
      din[k].ex_memread = 1'b1;
      din[k].ex_rd      = 5'd0;
      din[k].id_rs1     = 5'd0;
      din[k].id_use_rs1 = 1'b1;
    end
    step("lu_rd_zero_no_stall", E_RUN, E_RUN, E_RUN);
    for (int k = 0; k < 3; k++) begin
      din[k].ex_rd      = 5'd7;
      din[k].id_rs1     = 5'd3;
      din[k].id_rs2     = 5'd7;
      din[k].id_use_rs2 = 1'b1;
    end
    step("lu_rs2_hit", E_LU, E_LU, E_LU);
    idle_all();
    for (int k = 0; k < 3; k++) begin
      set_lu(k);
      din[k].id_use_rs1 = 1'b0;
    end
    step("lu_rs1_not_used", E_RUN, E_RUN, E_RUN);
    for (int k = 0; k < 3; k++) begin
      din[k].id_use_rs1 = 1'b1;
      din[k].ex_memread = 1'b0;
    end
    step("lu_not_load", E_RUN, E_RUN, E_RUN);
    idle_all();
  endtask

  task automatic test_mul();
    // MUL_LAT=2: one stall cycle, then the MUL advances.
    din[0].ex_is_mul = 1'b1;
    step("mul2_stall", E_MUL, E_RUN, E_RUN);
    step("mul2_release", E_RUN, E_RUN, E_RUN);
    idle_all();
    step("mul2_after", E_RUN, E_RUN, E_RUN);
    // MUL_LAT=4: exactly three stall cycles; load-use behind it waits.
    din[2].ex_is_mul = 1'b1;
    step("mul4_stall1", E_RUN, E_RUN, E_MUL);
    set_lu(2);
    step("mul4_stall2_lu_ignored", E_RUN, E_RUN, E_MUL);
    step("mul4_stall3_lu_ignored", E_RUN, E_RUN, E_MUL);
    step("mul4_release_lu_seen", E_RUN, E_RUN, E_LU);
    idle_all();
    step("mul4_after", E_RUN, E_RUN, E_RUN);
  endtask

  task automatic test_branch();
    // Branch on the MUL-entry cycle: flush wins and no stall follows.
    din[1].ex_is_mul    = 1'b1;
    din[1].mem_br_taken = 1'b1;
    step("br_on_mul_entry", E_RUN, E_FLUSH, E_RUN);
    idle_all();
    step("br_no_mul_stall_after", E_RUN, E_RUN, E_RUN);
    // Branch in the middle of a MUL_LAT=4 stall aborts it.
    din[2].ex_is_mul = 1'b1;
    step("br_mid_mul_stall", E_RUN, E_RUN, E_MUL);
    din[2].mem_br_taken = 1'b1;
    step("br_mid_mul_flush", E_RUN, E_RUN, E_FLUSH);
    idle_all();
    step("br_mid_mul_aborted", E_RUN, E_RUN, E_RUN);
    // Flush beats load-use.
    for (int k = 0; k < 3; k++) begin
      set_lu(k);
      din[k].mem_br_taken = 1'b1;
    end
    step("br_beats_lu", E_FLUSH, E_FLUSH, E_FLUSH);
    idle_all();
    step("br_after", E_RUN, E_RUN, E_RUN);
  endtask

  task automatic test_back_to_back();
    // MUL_LAT=3 with a continuous stream of MULs: stall 2, release 1, ...
    din[1].ex_is_mul = 1'b1;
    step("b2b_mul1_s1", E_RUN, E_MUL, E_RUN);
    step("b2b_mul1_s2", E_RUN, E_MUL, E_RUN);
    step("b2b_mul1_rel", E_RUN, E_RUN, E_RUN);
    step("b2b_mul2_s1", E_RUN, E_MUL, E_RUN);
    step("b2b_mul2_s2", E_RUN, E_MUL, E_RUN);
    step("b2b_mul2_rel", E_RUN, E_RUN, E_RUN);
    idle_all();
    step("b2b_after", E_RUN, E_RUN, E_RUN);
    // Reset mid-stall: outputs drop at once, nothing lingers afterwards.
    din[1].ex_is_mul = 1'b1;
    step("arst_mid_mul_stall", E_RUN, E_MUL, E_RUN);
    arst = 1'b1;
    step("arst_mid_mul_zero1", E_ZERO, E_ZERO, E_ZERO);
    step("arst_mid_mul_zero2", E_ZERO, E_ZERO, E_ZERO);
    idle_all();
    arst = 1'b0;
    step("arst_mid_mul_release", E_RUN, E_RUN, E_RUN);
    step("arst_mid_mul_idle", E_RUN, E_RUN, E_RUN);
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_CNT_EN
    arst = 1'b1;
    step("perf_reset", E_ZERO, E_ZERO, E_ZERO);
    arst = 1'b0;
    step("perf_release", E_RUN, E_RUN, E_RUN);
    set_lu(0);
    step("perf_lu", E_LU, E_RUN, E_RUN);
    idle_all();
    step("perf_lu_bubble", E_RUN, E_RUN, E_RUN);
    din[0].ex_is_mul = 1'b1;
    step("perf_mul", E_MUL, E_RUN, E_RUN);
    step("perf_mul_release", E_RUN, E_RUN, E_RUN);
    idle_all();
    step("perf_idle", E_RUN, E_RUN, E_RUN);
    din[0].mem_br_taken = 1'b1;
    step("perf_branch", E_FLUSH, E_RUN, E_RUN);
    idle_all();
    step("perf_after", E_RUN, E_RUN, E_RUN);
    checks++;
    if (stall_cnt[0] !== 32'd2) begin
      failures++;
      $display("FAIL perf_stall_cnt got=%0d expected=2", stall_cnt[0]);
    end
    checks++;
    if (flush_cnt[0] !== 32'd1) begin
      failures++;
      $display("FAIL perf_flush_cnt got=%0d expected=1", flush_cnt[0]);
    end
    checks++;
    if (stall_cnt[1] !== 32'd0 || flush_cnt[1] !== 32'd0) begin
      failures++;
      $display("FAIL perf_idle_dut_cnts got=%0d/%0d expected=0/0",
               stall_cnt[1], flush_cnt[1]);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1;
    idle_all();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_mul();
    test_branch();
    test_back_to_back();
    test_perf();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
